// File: rtl/requestor_mem_arbiter.sv
// requestor_mem_arbiter: N-way ready/valid arbiter into a one-entry registered memory request stage, with tagged response demux.
module requestor_mem_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int RR     = 0,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          io_requestor_req_valid,
  output logic [N_REQ-1:0]          io_requestor_req_ready,
  input  logic [N_REQ*DATA_W-1:0]   io_requestor_req_bits,
  output logic [N_REQ-1:0]          io_requestor_resp_valid,
  output logic [DATA_W-1:0]         io_requestor_resp_bits,
  output logic                      io_mem_req_valid,
  input  logic                      io_mem_req_ready,
  output logic [DATA_W-1:0]         io_mem_req_bits,
  output logic [ID_W-1:0]           io_mem_req_id,
  input  logic                      io_mem_resp_valid,
  input  logic [DATA_W-1:0]         io_mem_resp_bits,
  input  logic [ID_W-1:0]           io_mem_resp_id,
  output logic                      io_err
);
  logic [ID_W-1:0] rr_ptr, gidx, j;
  logic [N_REQ-1:0] grant, resp_hit;
  logic free, xfer;
  function automatic int scan_idx(input logic [ID_W-1:0] p, input int k);
    return RR != 0 ? (int'(p) + k) % N_REQ : N_REQ - k;
  endfunction
  // Scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    gidx = '0;
    j = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = ID_W'(scan_idx(rr_ptr, k));
      if (io_requestor_req_valid[j]) gidx = j;
    end
  end
  always_comb begin
    resp_hit = '0;
    for (int k = 0; k < N_REQ; k++) resp_hit[k] = io_mem_resp_id == ID_W'(k);
  end
  assign free = !io_mem_req_valid || io_mem_req_ready;
  assign grant = |io_requestor_req_valid ? N_REQ'(1) << gidx : '0;
  assign io_requestor_req_ready = (reset || !free) ? '0 : grant;
  assign xfer = |io_requestor_req_ready;
  assign io_requestor_resp_valid = (reset || !io_mem_resp_valid) ? '0 : resp_hit;
  assign io_requestor_resp_bits = io_mem_resp_bits;
  always_ff @(posedge clk) begin
    if (reset) begin
      io_mem_req_valid <= 1'b0;
      io_mem_req_bits <= '0;
      io_mem_req_id <= '0;
      io_err <= 1'b0;
      rr_ptr <= ID_W'(N_REQ - 1);
    end else begin
      if (free) io_mem_req_valid <= xfer;
      if (xfer) begin
        io_mem_req_bits <= io_requestor_req_bits[int'(gidx)*DATA_W +: DATA_W];
        io_mem_req_id <= gidx;
        rr_ptr <= gidx;
      end
      if (io_mem_resp_valid && !(|resp_hit)) io_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_requestor_mem_arbiter.sv
// tb_requestor_mem_arbiter: fixed-priority and round-robin 4-way instances plus a 3-way instance for the bad-tag error path.
module tb_requestor_mem_arbiter;
  logic clk = 0, reset = 1;
  logic [3:0] rv = 0;
  logic [127:0] rb = 0;
  logic mrdy = 0, rspv = 0;
  logic [31:0] rspb = 0;
  logic [1:0] rspid = 0;
  logic [3:0] rdy[2], rsv[2];
  logic [31:0] rsb[2], mb[2];
  logic mv[2], err[2];
  logic [1:0] mid[2];
  logic [2:0] rdy3, rsv3;
  logic [31:0] rsb3, mb3;
  logic mv3, err3;
  logic [1:0] mid3;
  bit m_v[2];
  logic [31:0] m_b[2];
  int m_id[2], m_rr[2];
  bit m_err3;
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] v; logic r; logic [3:0] er; logic ev; logic [1:0] eid;} vec_t;
  vec_t tbl[10];
  always #5 clk = ~clk;
  requestor_mem_arbiter #(.N_REQ(4), .DATA_W(32), .RR(0)) dut0 (
    .clk(clk), .reset(reset), .io_requestor_req_valid(rv), .io_requestor_req_ready(rdy[0]),
    .io_requestor_req_bits(rb), .io_requestor_resp_valid(rsv[0]), .io_requestor_resp_bits(rsb[0]),
    .io_mem_req_valid(mv[0]), .io_mem_req_ready(mrdy), .io_mem_req_bits(mb[0]), .io_mem_req_id(mid[0]),
    .io_mem_resp_valid(rspv), .io_mem_resp_bits(rspb), .io_mem_resp_id(rspid), .io_err(err[0]));
  requestor_mem_arbiter #(.N_REQ(4), .DATA_W(32), .RR(1)) dut1 (
    .clk(clk), .reset(reset), .io_requestor_req_valid(rv), .io_requestor_req_ready(rdy[1]),
    .io_requestor_req_bits(rb), .io_requestor_resp_valid(rsv[1]), .io_requestor_resp_bits(rsb[1]),
    .io_mem_req_valid(mv[1]), .io_mem_req_ready(mrdy), .io_mem_req_bits(mb[1]), .io_mem_req_id(mid[1]),
    .io_mem_resp_valid(rspv), .io_mem_resp_bits(rspb), .io_mem_resp_id(rspid), .io_err(err[1]));
  requestor_mem_arbiter #(.N_REQ(3), .DATA_W(32), .RR(1)) dut3 (
    .clk(clk), .reset(reset), .io_requestor_req_valid(3'b000), .io_requestor_req_ready(rdy3),
    .io_requestor_req_bits(96'd0), .io_requestor_resp_valid(rsv3), .io_requestor_resp_bits(rsb3),
    .io_mem_req_valid(mv3), .io_mem_req_ready(mrdy), .io_mem_req_bits(mb3), .io_mem_req_id(mid3),
    .io_mem_resp_valid(rspv), .io_mem_resp_bits(rspb), .io_mem_resp_id(rspid), .io_err(err3));

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  function automatic int winner(input int c, input logic [3:0] v);
    if (c == 0) begin
      for (int i = 3; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (v[(m_rr[c] + k) % 4]) return (m_rr[c] + k) % 4;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    int w[2];
    bit fr[2];
    #1;
    for (int c = 0; c < 2; c++) begin
      fr[c] = !m_v[c] || mrdy;
      w[c] = winner(c, rv);
      chk($sformatf("dut%0d req_ready", c), rdy[c], (reset || !fr[c] || w[c] < 0) ? 0 : 1 << w[c]);
      chk($sformatf("dut%0d resp_valid", c), rsv[c], (reset || !rspv) ? 0 : 1 << rspid);
      chk($sformatf("dut%0d resp_bits", c), rsb[c], rspb);
    end
    chk("n3 resp_valid", rsv3, (reset || !rspv || rspid == 3) ? 0 : 1 << rspid);
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        m_v[c] = 0; m_b[c] = 0; m_id[c] = 0; m_rr[c] = 3;
      end else if (fr[c]) begin
        m_v[c] = w[c] >= 0;
        if (w[c] >= 0) begin
          m_b[c] = rb[w[c]*32 +: 32]; m_id[c] = w[c]; m_rr[c] = w[c];
        end
      end
    end
    m_err3 = reset ? 0 : (m_err3 || (rspv && rspid == 3));
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("dut%0d mem_req_valid", c), mv[c], m_v[c]);
      chk($sformatf("dut%0d mem_req_bits", c), mb[c], m_b[c]);
      chk($sformatf("dut%0d mem_req_id", c), mid[c], m_id[c]);
      chk($sformatf("dut%0d err", c), err[c], 0);
    end
    chk("n3 err", err3, m_err3);
  endtask

  initial begin
    tbl[0] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[1] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[2] = '{4'h3, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[3] = '{4'h3, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[4] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[5] = '{4'h5, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[6] = '{4'h1, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[7] = '{4'h1, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[8] = '{4'h0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[9] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    for (int c = 0; c < 2; c++) begin
      m_v[c] = 0; m_b[c] = 0; m_id[c] = 0; m_rr[c] = 3;
    end
    m_err3 = 0;
    step();
    step();
    reset = 0;
    rb = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    for (int i = 0; i < 10; i++) begin
      rv = tbl[i].v;
      mrdy = tbl[i].r;
      #1 chk($sformatf("tbl%0d ready", i), rdy[0], tbl[i].er);
      step();
      chk($sformatf("tbl%0d valid", i), mv[0], tbl[i].ev);
      chk($sformatf("tbl%0d id", i), mid[0], tbl[i].eid);
    end
    reset = 1; rv = 0;
    step();
    reset = 0; rv = 4'hF; mrdy = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("rr grant%0d", i), rdy[1], 1 << (i % 4));
      step();
      chk($sformatf("rr id%0d", i), mid[1], i % 4);
    end
    rb[31:0] = 32'hA5; rv = 4'b0001; mrdy = 1;
    step();
    rv = 4'b0110; mrdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall bits fp", mb[0], 32'hA5);
      chk("stall bits rr", mb[1], 32'hA5);
    end
    mrdy = 1;
    step();
    chk("release fp id", mid[0], 2);
    chk("release rr id", mid[1], 1);
    rv = 4'b0010; rb[63:32] = 32'h111;
    step();
    chk("b2b first", mb[0], 32'h111);
    rv = 4'b0100; rb[95:64] = 32'h222;
    step();
    chk("b2b second", mb[0], 32'h222);
    chk("b2b valid", mv[0], 1);
    rspv = 1; rspid = 2; rspb = 32'h1234;
    #1 chk("resp strobe", rsv[0], 4'b0100);
    chk("resp bits", rsb[0], 32'h1234);
    step();
    rspid = 3;
    #1 chk("n3 bad id strobe", rsv3, 0);
    step();
    chk("n3 err set", err3, 1);
    rspv = 0;
    step();
    chk("n3 err sticky", err3, 1);
    rv = 4'b0001; mrdy = 1;
    step();
    mrdy = 0;
    step();
    reset = 1;
    step();
    chk("reset drops req", mv[0], 0);
    chk("reset clears err", err3, 0);
    reset = 0; rv = 4'hF; mrdy = 1;
    #1 chk("reset rr_ptr", rdy[1], 4'b0001);
    step();
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom);
      mrdy = $urandom_range(0, 3) != 0;
      rb = {$urandom, $urandom, $urandom, $urandom};
      rspv = 1'($urandom);
      rspid = 2'($urandom);
      rspb = $urandom;
      reset = $urandom_range(0, 49) == 0;
      step();
    end
    reset = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
